rf_banked_mp: RTL

//  Parametrised multi-port register file for the pipelined core; replaces the fixed 2R/1W 16x32 file.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_bank_map.sv | 29 ++
 rtl/rf_banked_mp.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: mode encodings, default banking layout and
// the logical-to-physical index helper used by the hazard unit.
package rf_pkg;

    localparam int unsigned MODE_USR = 0;
    localparam int unsigned MODE_IRQ = 1;

    localparam int unsigned DEF_ADDR_W    = 4;
    localparam int unsigned DEF_BANK_BASE = 13;
    localparam int unsigned DEF_BANK_CNT  = 2;

    // Physical slot for a logical register in the default layout. Banked registers
    // seen from a non-user mode live after the 2**ADDR_W user entries.
    function automatic int unsigned phys_idx(input int unsigned addr, input int unsigned mode);
        if (mode != MODE_USR && addr >= DEF_BANK_BASE && addr < DEF_BANK_BASE + DEF_BANK_CNT) begin
            return (32'd1 << DEF_ADDR_W) + (mode - 1) * DEF_BANK_CNT + (addr - DEF_BANK_BASE);
        end
        return addr;
    endfunction

endpackage

// File: rtl/rf_bank_map.sv
// Combinational logical->physical register index translation for one port.
module rf_bank_map import rf_pkg::*; #(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MODE_W    = 1,
    parameter int unsigned BANK_BASE = DEF_BANK_BASE,
    parameter int unsigned BANK_CNT  = DEF_BANK_CNT,
    parameter int unsigned IDX_W     = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [IDX_W-1:0]  idx_o
);

    logic [31:0] addr_w;
    logic [31:0] mode_w;

    assign addr_w = 32'(addr_i);
    assign mode_w = 32'(mode_i);

    // Banked addresses in a non-user mode go to that mode's shadow slots.
    always_comb begin
        idx_o = IDX_W'(addr_w);
        if (mode_w != MODE_USR && addr_w >= BANK_BASE && addr_w < BANK_BASE + BANK_CNT) begin
            idx_o = IDX_W'((32'd1 << ADDR_W) + (mode_w - 32'd1) * BANK_CNT
                           + (addr_w - BANK_BASE));
        end
    end

endmodule

// File: rtl/rf_banked_mp.sv
// Multi-port banked register file: NUM_RD combinational read ports with write-first
// bypass, two write ports (port 1 younger), per-mode shadow registers and a busy
// scoreboard for decode-stage hazard detection.
module rf_banked_mp import rf_pkg::*; #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned BANK_BASE = DEF_BANK_BASE,
    parameter int unsigned BANK_CNT  = DEF_BANK_CNT,
    localparam int unsigned MODE_W   = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic                     sb_set_i,
    input  logic [ADDR_W-1:0]        sb_addr_i,
    input  logic                     mode_we_i,
    input  logic [MODE_W-1:0]        mode_in_i,
    output logic [MODE_W-1:0]        mode_out_o
);

    localparam int unsigned PHYS  = (32'd1 << ADDR_W) + (NUM_MODES - 1) * BANK_CNT;
    localparam int unsigned IDX_W = (PHYS > 1) ? $clog2(PHYS) : 1;

    logic [DATA_W-1:0] regs_q [PHYS];
    logic [PHYS-1:0]   busy_q, busy_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    logic [IDX_W-1:0]  widx0, widx1, sbidx;

    rf_bank_map #(
        .ADDR_W(ADDR_W), .MODE_W(MODE_W), .BANK_BASE(BANK_BASE), .BANK_CNT(BANK_CNT),
        .IDX_W(IDX_W)
    ) u_map_w0 (.addr_i(waddr0_i), .mode_i(mode_q), .idx_o(widx0));

    rf_bank_map #(
        .ADDR_W(ADDR_W), .MODE_W(MODE_W), .BANK_BASE(BANK_BASE), .BANK_CNT(BANK_CNT),
        .IDX_W(IDX_W)
    ) u_map_w1 (.addr_i(waddr1_i), .mode_i(mode_q), .idx_o(widx1));

    rf_bank_map #(
        .ADDR_W(ADDR_W), .MODE_W(MODE_W), .BANK_BASE(BANK_BASE), .BANK_CNT(BANK_CNT),
        .IDX_W(IDX_W)
    ) u_map_sb (.addr_i(sb_addr_i), .mode_i(mode_q), .idx_o(sbidx));

    // Storage update; port 1 is assigned last so it wins a same-entry collision.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < PHYS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we0_i) regs_q[widx0] <= wdata0_i;
            if (we1_i) regs_q[widx1] <= wdata1_i;
        end
    end

    // Writes retire producers; a new issue to the same entry re-arms the bit.
    always_comb begin
        busy_d = busy_q;
        if (we0_i)    busy_d[widx0] = 1'b0;
        if (we1_i)    busy_d[widx1] = 1'b0;
        if (sb_set_i) busy_d[sbidx] = 1'b1;
    end

    // Out-of-range mode requests leave the mode untouched.
    always_comb begin
        mode_d = mode_q;
        if (mode_we_i && 32'(mode_in_i) < NUM_MODES) begin
            mode_d = mode_in_i;
        end
    end

    // Scoreboard and mode state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            mode_q <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
        end
    end

    assign mode_out_o = mode_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0]  ridx;
        logic              hit0, hit1, sb_hit;
        logic [DATA_W-1:0] rdat;

        rf_bank_map #(
            .ADDR_W(ADDR_W), .MODE_W(MODE_W), .BANK_BASE(BANK_BASE), .BANK_CNT(BANK_CNT),
            .IDX_W(IDX_W)
        ) u_map_rd (.addr_i(rd_addr_i[k*ADDR_W +: ADDR_W]), .mode_i(mode_q), .idx_o(ridx));

        assign hit0   = we0_i && (widx0 == ridx);
        assign hit1   = we1_i && (widx1 == ridx);
        assign sb_hit = sb_set_i && (sbidx == ridx);

        // Write-first bypass, younger port taking priority.
        always_comb begin
            rdat = regs_q[ridx];
            if (hit0) rdat = wdata0_i;
            if (hit1) rdat = wdata1_i;
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rdat;
        // A retiring write hides the busy bit unless a new producer is issued this cycle.
        assign rd_busy_o[k] = busy_q[ridx] && !((hit0 || hit1) && !sb_hit);
    end

endmodule
